// File: rtl/sysbus_download_master.sv
// rtl/sysbus_download_master.sv - host byte-stream to system peripheral bus initiator for download mode
module sysbus_download_master #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1_000_000,
    parameter int RD_LAT  = 1
) (
    input  logic              hb_clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] bus_raddr,
    output logic [ADDR_W-1:0] bus_waddr,
    output logic [31:0]       bus_wdata,
    output logic              bus_ren,
    output logic              bus_wen,
    input  logic [31:0]       bus_rdata,
    output logic              busy
);

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;
    localparam int         TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS_WR,
        S_BUS_RD,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              is_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       wbuf;
    logic [31:0]       wdata_q;
    logic [31:0]       resp_q;
    logic [1:0]        idx;
    logic [1:0]        last_idx;
    logic [TO_W-1:0]   to_cnt;
    logic [2:0]        lat_cnt;

    logic              accept;
    logic              timed_out;
    logic              lat_done;
    logic [ADDR_W+7:0] addr_ext;

    assign accept    = rx_valid && rx_ready;
    assign timed_out = (to_cnt == TO_W'(TIMEOUT - 1)) && !accept;
    assign lat_done  = (lat_cnt == 3'(RD_LAT - 1));
    // Widen first so the address byte either zero-extends or truncates cleanly.
    assign addr_ext  = {{ADDR_W{1'b0}}, rx_data};

    assign bus_raddr = addr_q;
    assign bus_waddr = addr_q;
    assign bus_wdata = wdata_q;
    assign tx_data   = resp_q[{idx, 3'b000} +: 8];
    assign busy      = (state != S_IDLE);

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        bus_wen  = 1'b0;
        bus_ren  = 1'b0;
        case (state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (accept) begin
                    state_nx = (rx_data == OP_WR || rx_data == OP_RD) ? S_ADDR : S_RESP;
                end
            end
            S_ADDR: begin
                rx_ready = 1'b1;
                if (accept) begin
                    state_nx = is_wr ? S_DATA : S_BUS_RD;
                end else if (timed_out) begin
                    state_nx = S_IDLE;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (accept && idx == 2'd3) begin
                    state_nx = S_BUS_WR;
                end else if (timed_out) begin
                    state_nx = S_IDLE;
                end
            end
            S_BUS_WR: begin
                bus_wen  = 1'b1;
                state_nx = S_RESP;
            end
            S_BUS_RD: begin
                bus_ren  = 1'b1;
                state_nx = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_done) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                tx_valid = 1'b1;
                if (tx_ready && idx == last_idx) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr    <= 1'b0;
            addr_q   <= '0;
            wbuf     <= '0;
            wdata_q  <= '0;
            resp_q   <= '0;
            idx      <= '0;
            last_idx <= '0;
            to_cnt   <= '0;
            lat_cnt  <= '0;
        end else begin
            to_cnt <= '0;
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (accept) begin
                        is_wr    <= (rx_data == OP_WR);
                        resp_q   <= {24'h0, NAK};
                        last_idx <= '0;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (accept) begin
                        if (state == S_ADDR) begin
                            addr_q <= addr_ext[ADDR_W-1:0];
                            idx    <= '0;
                        end else if (idx == 2'd3) begin
                            // The full word lands at once so bus_wdata never shows a partial frame.
                            wdata_q <= {rx_data, wbuf};
                            idx     <= '0;
                        end else begin
                            wbuf[{idx, 3'b000} +: 8] <= rx_data;
                            idx                      <= idx + 2'd1;
                        end
                    end else if (!timed_out) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_BUS_WR: begin
                    resp_q   <= {24'h0, ACK};
                    idx      <= '0;
                    last_idx <= '0;
                end
                S_BUS_RD: begin
                    lat_cnt <= '0;
                end
                S_RD_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_done) begin
                        resp_q   <= bus_rdata;
                        idx      <= '0;
                        last_idx <= 2'd3;
                    end
                end
                S_RESP: begin
                    if (tx_ready) begin
                        idx <= (idx == last_idx) ? 2'd0 : idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_download_master.sv
// tb/tb_sysbus_download_master.sv - scoreboard bench for sysbus_download_master
module tb_sysbus_download_master;

    localparam int TIMEOUT = 20;
    localparam int RD_LAT  = 1;

    logic        hb_clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  bus_raddr;
    logic [7:0]  bus_waddr;
    logic [31:0] bus_wdata;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_rdata;
    logic        busy;

    sysbus_download_master #(
        .ADDR_W(8), .TIMEOUT(TIMEOUT), .RD_LAT(RD_LAT)
    ) dut (
        .hb_clk(hb_clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_raddr(bus_raddr), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
        .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    always #5 hb_clk = ~hb_clk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } bus_ev_t;

    bus_ev_t    exp_bus[$];
    logic [7:0] exp_tx[$];
    int         checks = 0;
    int         errors = 0;
    int         tx_count = 0;
    logic       stall_mode = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push_bus(logic wr, logic [7:0] addr, logic [31:0] data);
        bus_ev_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        exp_bus.push_back(e);
    endfunction

    // Responder: registered read data valid only for the single cycle after bus_ren.
    function automatic logic [31:0] rd_value(logic [7:0] a);
        case (a)
            8'h00:   return 32'hA5A5_0001;
            8'h02:   return 32'h1234_5678;
            8'h05:   return 32'hCAFE_F00D;
            default: return 32'h0BAD_0BAD;
        endcase
    endfunction

    initial begin
        bus_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge hb_clk);
            bus_rdata <= bus_ren ? rd_value(bus_raddr) : 32'hDEAD_BEEF;
        end
    end

    initial begin
        int scnt;
        scnt = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge hb_clk);
            #2;
            if (!stall_mode) begin
                tx_ready = 1'b1;
            end else if (tx_valid && !tx_ready) begin
                scnt++;
                if (scnt >= 10) tx_ready = 1'b1;
            end else begin
                tx_ready = 1'b0;
                scnt = 0;
            end
        end
    end

    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge hb_clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (tx_valid) check("rx_ready_in_resp", rx_ready, 0);
                if (prev_stall) begin
                    check("tx_valid_held", tx_valid, 1);
                    check("tx_data_stable", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        check("tx_unexpected", 1, 0);
                    end else begin
                        e = exp_tx.pop_front();
                        check("tx_byte", tx_data, e);
                    end
                    tx_count++;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    initial begin
        logic    prev_strobe;
        bus_ev_t e;
        prev_strobe = 1'b0;
        forever begin
            @(negedge hb_clk);
            if (bus_wen || bus_ren) begin
                check("strobe_exclusive", bus_wen && bus_ren, 0);
                check("strobe_one_cycle", prev_strobe, 0);
                if (exp_bus.size() == 0) begin
                    check("strobe_unexpected", 1, 0);
                end else begin
                    e = exp_bus.pop_front();
                    check("strobe_kind", bus_wen, e.wr);
                    if (e.wr) begin
                        check("bus_waddr", bus_waddr, e.addr);
                        check("bus_wdata", bus_wdata, e.data);
                    end else begin
                        check("bus_raddr", bus_raddr, e.addr);
                    end
                end
            end
            prev_strobe = bus_wen || bus_ren;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge hb_clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge hb_clk);
            n++;
        end
        if (n >= 200) check("rx_accept_timeout", 0, 1);
        @(posedge hb_clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge hb_clk);
        while (busy && n < 1000) begin
            @(negedge hb_clk);
            n++;
        end
        check("return_to_idle", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(negedge hb_clk);
        rst_n = 1'b1;
        @(negedge hb_clk);
        check("reset_rx_ready", rx_ready, 1);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_strobes", {bus_wen, bus_ren}, 0);
        check("reset_wdata", bus_wdata, 0);
        check("reset_raddr", bus_raddr, 0);

        push_bus(1'b1, 8'h00, 32'h0000_00F0);
        exp_tx.push_back(8'h06);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'hF0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("wen_latency", bus_wen, 1);
        @(posedge hb_clk);
        #1 check("ack_latency", tx_valid, 1);
        wait_idle();

        push_bus(1'b0, 8'h02, 32'h0);
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        send_byte(8'h52); send_byte(8'h02);
        wait_idle();

        exp_tx.push_back(8'h15);
        send_byte(8'hAA);
        wait_idle();
        push_bus(1'b0, 8'h00, 32'h0);
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h00);
        exp_tx.push_back(8'hA5); exp_tx.push_back(8'hA5);
        send_byte(8'h52); send_byte(8'h00);
        wait_idle();

        send_byte(8'h57); send_byte(8'h05); send_byte(8'h11);
        repeat (TIMEOUT + 5) @(negedge hb_clk);
        check("timeout_idle", busy, 0);
        push_bus(1'b0, 8'h05, 32'h0);
        exp_tx.push_back(8'h0D); exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'hFE); exp_tx.push_back(8'hCA);
        send_byte(8'h52); send_byte(8'h05);
        wait_idle();

        stall_mode = 1'b1;
        push_bus(1'b0, 8'h02, 32'h0);
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        send_byte(8'h52); send_byte(8'h02);
        wait_idle();

        base = tx_count;
        push_bus(1'b0, 8'h02, 32'h0);
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
        send_byte(8'h52); send_byte(8'h02);
        n = 0;
        @(negedge hb_clk);
        while (!(tx_count == base + 2 && tx_valid) && n < 500) begin
            @(negedge hb_clk);
            n++;
        end
        check("third_byte_reached", n < 500, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge hb_clk);
        rst_n = 1'b1;
        repeat (40) @(negedge hb_clk);
        check("no_bytes_after_reset", tx_count, base + 2);
        stall_mode = 1'b0;

        repeat (2) @(negedge hb_clk);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("bus_queue_drained", exp_bus.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
